fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single FIFO write port (winc/wdata, qualified by wfull) among NREQ producers in the write clock domain. It grants ownership of the port for a burst of up to MAX_BURST words per requester, which keeps packets contiguous in the FIFO. It sits in front of the FIFO write-pointer block and drives its winc.

---
 rtl/fifo_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding, default
// sizing and the owner-index width helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NREQ      = 4;
    localparam int DEFAULT_DW        = 8;
    localparam int DEFAULT_MAX_BURST = 4;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first asserted request when
// scanning rr_ptr, rr_ptr+1, ... modulo N. The read side can reuse it as is.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_NREQ,
    localparam int W = owner_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic         valid,
    output logic [W-1:0] index
);

    logic [W-1:0] idx;

    // Scan from the farthest slot back to rr_ptr so the nearest hit wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        valid = 1'b0;
        index = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(rr_ptr) + k) % N);
            if (req[idx]) begin
                valid = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single FIFO write port. Define
// WR_ARB_STATS_EN to add per-requester write counters and a stall counter.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = DEFAULT_NREQ,
    parameter int DW        = DEFAULT_DW,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*DW-1:0]       wdata_in,
    input  logic                     wfull,
    output logic [NREQ-1:0]          gnt,
    output logic                     winc,
    output logic [DW-1:0]            wdata,
    output logic [owner_w(NREQ)-1:0] owner,
    output logic                     busy
`ifdef WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]       wr_count,
    output logic [15:0]              stall_count
`endif
);

    localparam int OW = owner_w(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t    state;
    logic [OW-1:0] rr_ptr;
    logic [BW-1:0] beat_cnt;
    logic          pick_valid;
    logic [OW-1:0] pick_index;
    logic          accept;
    logic          burst_end;
    logic [OW-1:0] owner_next;
    logic [DW-1:0] slice [NREQ];

    fifo_wr_arbiter_rr_pick #(.N(NREQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_index)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slice[i] = wdata_in[i*DW +: DW];
        end
    end

    assign busy       = (state == OWN);
    assign accept     = busy & req[owner] & ~wfull;
    assign winc       = accept;
    assign wdata      = busy ? slice[owner] : '0;
    assign burst_end  = accept & (last[owner] | (beat_cnt + 1'b1 == BW'(MAX_BURST)));
    assign owner_next = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        gnt        = '0;
        gnt[owner] = accept;
    end

    // Ownership is always released through IDLE, giving a one-cycle gap
    // between owners even when another request is already waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_index;
                        beat_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (burst_end || !req[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= owner_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [15:0] wr_cnt_q [NREQ];
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_cnt_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && owner == OW'(i) && wr_cnt_q[i] != 16'hFFFF) begin
                    wr_cnt_q[i] <= wr_cnt_q[i] + 16'd1;
                end
            end
            if (busy && req[owner] && wfull && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wr_count[i*16 +: 16] = wr_cnt_q[i];
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised bench for fifo_wr_arbiter against a behavioural reference model;
// WR_ARB_STATS_EN also exercises the statistics counters.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N*DW-1:0] wdata_in;
    logic          wfull;
    logic [N-1:0]  gnt;
    logic          winc;
    logic [DW-1:0] wdata;
    logic [1:0]    owner;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the port, how many words it has written in
    // this burst, and where the next round-robin scan starts.
    bit          m_busy;
    int          m_owner;
    int          m_words;
    int          m_rr;
    logic [N-1:0] m_gnt_last;
    int unsigned m_wr [N];
    int unsigned m_stall;

`ifdef WR_ARB_STATS_EN
    logic [N*16-1:0] wr_count;
    logic [15:0]     stall_count;
    logic [1:0]      sat_req = 2'b00;
    logic [1:0]      sat_gnt;
    logic            sat_winc;
    logic [7:0]      sat_wdata;
    logic [0:0]      sat_owner;
    logic            sat_busy;
    logic [31:0]     sat_wr;
    logic [15:0]     sat_stall;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .last        (last),
        .wdata_in    (wdata_in),
        .wfull       (wfull),
        .gnt         (gnt),
        .winc        (winc),
        .wdata       (wdata),
        .owner       (owner),
        .busy        (busy)
`ifdef WR_ARB_STATS_EN
        ,
        .wr_count    (wr_count),
        .stall_count (stall_count)
`endif
    );

`ifdef WR_ARB_STATS_EN
    fifo_wr_arbiter #(.NREQ(2), .DW(8), .MAX_BURST(255)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .req         (sat_req),
        .last        (2'b00),
        .wdata_in    (16'h0000),
        .wfull       (1'b0),
        .gnt         (sat_gnt),
        .winc        (sat_winc),
        .wdata       (sat_wdata),
        .owner       (sat_owner),
        .busy        (sat_busy),
        .wr_count    (sat_wr),
        .stall_count (sat_stall)
    );
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_busy     = 1'b0;
        m_owner    = 0;
        m_words    = 0;
        m_rr       = 0;
        m_gnt_last = '0;
        m_stall    = 0;
        for (int i = 0; i < N; i++) m_wr[i] = 0;
    endtask

    task automatic new_word(input int i, input bit is_last);
        wdata_in[i*DW +: DW] = 8'($urandom);
        last[i] = is_last;
    endtask

    // Compare every output against the model mid-cycle, then step the model
    // and the clock; inputs change #1 after the rising edge.
    task automatic cycle();
        bit          acc;
        bit          found;
        logic [N-1:0] eg;
        logic [DW-1:0] ew;
        @(negedge clk);
        acc = m_busy && req[m_owner] && !wfull;
        eg  = acc ? N'(1 << m_owner) : '0;
        ew  = m_busy ? wdata_in[m_owner*DW +: DW] : '0;
        n_vec++;
        if (gnt !== eg) begin
            n_err++;
            $display("FAIL gnt t=%0t got %b want %b", $time, gnt, eg);
        end
        n_vec++;
        if (winc !== acc) begin
            n_err++;
            $display("FAIL winc t=%0t got %b want %b", $time, winc, acc);
        end
        n_vec++;
        if (busy !== m_busy) begin
            n_err++;
            $display("FAIL busy t=%0t got %b want %b", $time, busy, m_busy);
        end
        n_vec++;
        if (wdata !== ew) begin
            n_err++;
            $display("FAIL wdata t=%0t got %h want %h", $time, wdata, ew);
        end
        if (m_busy) begin
            n_vec++;
            if (owner !== 2'(m_owner)) begin
                n_err++;
                $display("FAIL owner t=%0t got %0d want %0d", $time, owner, m_owner);
            end
        end
`ifdef WR_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (wr_count[i*16 +: 16] !== 16'(m_wr[i])) begin
                n_err++;
                $display("FAIL wr_count[%0d] t=%0t got %0d want %0d", i, $time,
                         wr_count[i*16 +: 16], m_wr[i]);
            end
        end
        n_vec++;
        if (stall_count !== 16'(m_stall)) begin
            n_err++;
            $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_count, m_stall);
        end
`endif
        if (acc && m_wr[m_owner] < 16'hFFFF) m_wr[m_owner]++;
        if (m_busy && req[m_owner] && wfull && m_stall < 16'hFFFF) m_stall++;
        m_gnt_last = eg;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_rr + k) % N]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = (m_rr + k) % N;
                    m_words = 0;
                end
            end
        end else if (acc) begin
            m_words++;
            if (last[m_owner] || m_words == MB) begin
                m_busy = 1'b0;
                m_rr   = (m_owner + 1) % N;
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req   = '0;
        wfull = 1'b0;
        for (int c = 0; c < 4 && m_busy; c++) cycle();
        cycle();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req      = '1;
        last     = '0;
        wdata_in = 32'hA5A5_A5A5;
        wfull    = 1'b0;
        model_reset();
        #12;
        n_vec++;
        if (busy !== 1'b0 || gnt !== '0 || winc !== 1'b0 || wdata !== '0 || owner !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state got busy=%b gnt=%b winc=%b wdata=%h owner=%0d want all 0",
                     busy, gnt, winc, wdata, owner);
        end
        req = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int w = 0, pulses = 0, first = -1, lastc = -1;
        req = 4'b0100;
        new_word(2, 1'b0);
        for (int c = 0; c < 20 && w < 3; c++) begin
            cycle();
            if (m_gnt_last[2]) begin
                w++;
                pulses++;
                if (first < 0) first = c;
                lastc = c;
                if (w == 3) req[2] = 1'b0;
                else new_word(2, w == 2);
            end
        end
        n_vec++;
        if (pulses != 3 || lastc - first != 2) begin
            n_err++;
            $display("FAIL single_burst got %0d pulses over %0d cycles want 3 over 2",
                     pulses, lastc - first);
        end
        cycle();
        // rr_ptr should now favour requester 3 over requester 0.
        req = 4'b1001;
        new_word(0, 1'b1);
        new_word(3, 1'b1);
        cycle();
        n_vec++;
        if (owner !== 2'd3 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rr_after_single got owner=%0d busy=%b want owner=3 busy=1", owner, busy);
        end
        drain();
    endtask

    task automatic test_all_four();
        int start, pulses = 0;
        start = m_rr;
        req   = '1;
        last  = '0;
        for (int i = 0; i < N; i++) new_word(i, 1'b0);
        for (int c = 0; c < 25; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (m_gnt_last[i]) begin
                    n_vec++;
                    if (i != (start + pulses / MB) % N) begin
                        n_err++;
                        $display("FAIL rr_order word %0d got owner %0d want %0d",
                                 pulses, i, (start + pulses / MB) % N);
                    end
                    pulses++;
                    new_word(i, 1'b0);
                end
            end
        end
        n_vec++;
        if (pulses != 5 * MB) begin
            n_err++;
            $display("FAIL all_four_pulses got %0d want %0d", pulses, 5 * MB);
        end
        drain();
    endtask

    task automatic test_wfull();
        int w = 0, stall_left = 5, full_pulses = 0;
        req = 4'b0010;
        new_word(1, 1'b0);
        for (int c = 0; c < 30 && (w < MB || m_busy); c++) begin
            wfull = (w == 1 && stall_left > 0);
            if (wfull) stall_left--;
            cycle();
            if (m_gnt_last[1]) begin
                w++;
                if (wfull) full_pulses++;
                new_word(1, 1'b0);
            end
        end
        wfull = 1'b0;
        n_vec++;
        if (w != MB || full_pulses != 0 || stall_left != 0) begin
            n_err++;
            $display("FAIL wfull_burst got %0d words %0d during full want %0d words 0 during full",
                     w, full_pulses, MB);
        end
        drain();
    endtask

    task automatic test_drop();
        int first = -1, first_cnt = 0, next = -1;
        req = 4'b0011;
        new_word(0, 1'b0);
        new_word(1, 1'b0);
        for (int c = 0; c < 20 && next < 0; c++) begin
            cycle();
            if (first < 0 && m_busy) first = m_owner;
            for (int i = 0; i < N; i++) begin
                if (m_gnt_last[i]) begin
                    if (i == first) begin
                        first_cnt++;
                        new_word(i, 1'b0);
                        if (first_cnt == 2) req[i] = 1'b0;
                    end else if (next < 0) begin
                        next = i;
                    end
                end
            end
        end
        n_vec++;
        if (first_cnt != 2 || next != 1 - first) begin
            n_err++;
            $display("FAIL owner_drop got %0d words then owner %0d want 2 words then owner %0d",
                     first_cnt, next, 1 - first);
        end
        drain();
    endtask

    task automatic test_async_reset();
        req = '1;
        for (int i = 0; i < N; i++) new_word(i, 1'b0);
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || gnt !== '0 || winc !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got busy=%b gnt=%b winc=%b want 0 0 0", busy, gnt, winc);
        end
        model_reset();
        rst = 1'b0;
        cycle();
        cycle();
        n_vec++;
        if (owner !== 2'd0) begin
            n_err++;
            $display("FAIL restart_owner got %0d want 0", owner);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                        new_word(i, $urandom_range(2) == 0);
                    end
                end else if (m_gnt_last[i]) begin
                    new_word(i, $urandom_range(2) == 0);
                    if ($urandom_range(3) == 0) req[i] = 1'b0;
                end else if ($urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            wfull = ($urandom_range(3) == 0);
            cycle();
        end
        drain();
    endtask

`ifdef WR_ARB_STATS_EN
    task automatic test_stats();
        int w = 0, stall_left = 5;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        req = 4'b0001;
        new_word(0, 1'b0);
        for (int c = 0; c < 30 && (w < 3 || m_busy); c++) begin
            wfull = (w == 1 && stall_left > 0);
            if (wfull) stall_left--;
            cycle();
            if (m_gnt_last[0]) begin
                w++;
                new_word(0, w == 2);
            end
        end
        wfull = 1'b0;
        n_vec++;
        if (wr_count[15:0] !== 16'd3 || stall_count !== 16'd5) begin
            n_err++;
            $display("FAIL stats got wr_count0=%0d stall=%0d want 3 5", wr_count[15:0], stall_count);
        end
        drain();
    endtask

    task automatic test_saturation();
        sat_req = 2'b01;
        repeat (66000) @(posedge clk);
        #1;
        n_vec++;
        if (sat_wr[15:0] !== 16'hFFFF || sat_wr[31:16] !== 16'h0000) begin
            n_err++;
            $display("FAIL wr_count_saturate got %h %h want ffff 0000", sat_wr[15:0], sat_wr[31:16]);
        end
        sat_req = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wfull();
        test_drop();
        test_async_reset();
        test_random();
`ifdef WR_ARB_STATS_EN
        test_stats();
        test_saturation();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
